// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: control request/abort, memory read port and instruction outputs.
// The fetch unit takes the slave side; the control FSM / memory model takes the master side.
interface inst_fetch_unit_if #(
  parameter int WORD_SIZE = 16
);
  logic                 fetch_start;
  logic [WORD_SIZE-1:0] inst_addr;
  logic                 flush;
  logic [WORD_SIZE-1:0] fetch_addr;
  logic                 readM;
  logic [WORD_SIZE-1:0] mem_data;
  logic                 inputReady;
  logic [WORD_SIZE-1:0] inst_reg;
  logic                 inst_valid;
  logic                 fetch_busy;
  logic                 fetch_done;
  logic                 fetch_err;
  logic [WORD_SIZE-1:0] num_inst;

  modport slave (
    input  fetch_start, inst_addr, flush, mem_data, inputReady,
    output fetch_addr, readM, inst_reg, inst_valid, fetch_busy, fetch_done, fetch_err, num_inst
  );

  modport master (
    output fetch_start, inst_addr, flush, mem_data, inputReady,
    input  fetch_addr, readM, inst_reg, inst_valid, fetch_busy, fetch_done, fetch_err, num_inst
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC address -> single-word memory read -> instruction register.
// Define FETCH_COUNT_EN to enable the successful-fetch counter on num_inst.
module inst_fetch_unit #(
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  inst_fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [CNT_W-1:0]     wait_cnt;
  logic [WORD_SIZE-1:0] fetch_addr_q;
  logic [WORD_SIZE-1:0] inst_reg_q;
  logic                 inst_valid_q;

  // flush outranks everything, so data returning on a flush edge is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      fetch_addr_q <= '0;
      inst_reg_q   <= '0;
      inst_valid_q <= 1'b0;
    end else if (bus.flush) begin
      state        <= IDLE;
      inst_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (bus.fetch_start) begin
            fetch_addr_q <= bus.inst_addr;
            inst_valid_q <= 1'b0;
            wait_cnt     <= '0;
            state        <= REQ;
          end
        end
        REQ: begin
          if (bus.inputReady) begin
            inst_reg_q   <= bus.mem_data;
            inst_valid_q <= 1'b1;
            state        <= DONE;
          end else if (wait_cnt == LAST_WAIT) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fetch_addr = fetch_addr_q;
  assign bus.inst_reg   = inst_reg_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.readM      = (state == REQ);
  assign bus.fetch_busy = (state == REQ) || (state == DONE);
  assign bus.fetch_done = (state == DONE);
  assign bus.fetch_err  = (state == ERR);

`ifdef FETCH_COUNT_EN
  logic [WORD_SIZE-1:0] num_inst_q;

  // counts only REQ->DONE, which is exactly the non-flushed inputReady edge in REQ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_inst_q <= '0;
    end else if (!bus.flush && (state == REQ) && bus.inputReady) begin
      num_inst_q <= num_inst_q + WORD_SIZE'(1);
    end
  end

  assign bus.num_inst = num_inst_q;
`else
  assign bus.num_inst = '0;
`endif

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage between the program counter and instruction memory in the multicycle TSC CPU.
- On a control-FSM request it captures the PC's inst_addr and drives a single-word read on the memory port. It waits for inputReady, latches the returned word into the instruction register, and reports done.
- Supports abort via flush and a bounded wait with an error flag.

Parameters:
- WORD_SIZE, 16, width of address, data and instruction words
- TIMEOUT_CYCLES, 64, max cycles in REQ without inputReady before ERR (must be >= 1)
- CNT_W, 7, width of the wait counter (must hold TIMEOUT_CYCLES)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- fetch_start  in  1  request from control FSM; accepted only in IDLE or ERR
- inst_addr  in  WORD_SIZE  fetch address from PC, sampled on accept
- flush  in  1  abort current fetch and invalidate inst_reg
- fetch_addr  out  WORD_SIZE  memory address, registered, stable for the whole request
- readM  out  1  memory read strobe; high exactly while state == REQ
- mem_data  in  WORD_SIZE  memory read data, valid when inputReady is high
- inputReady  in  1  memory completion; meaningful only in REQ
- inst_reg  out  WORD_SIZE  latched instruction word
- inst_valid  out  1  inst_reg holds the word for the last accepted address
- fetch_busy  out  1  high in REQ and DONE
- fetch_done  out  1  one-cycle pulse, high while state == DONE
- fetch_err  out  1  high while state == ERR
- num_inst  out  WORD_SIZE  successful fetch count (see Optional Feature)

Behaviour:
- States: IDLE, REQ, DONE, ERR. Encoding is free; outputs are decoded from the state or held in registers, with no combinational path from inputs to outputs.
- Reset (reset_n low, asynchronous): state=IDLE; fetch_addr, inst_reg and num_inst = 0; inst_valid=0; wait counter=0. Every output is therefore 0 during reset.
- IDLE/ERR with fetch_start=1 at an edge:
  - fetch_addr <= inst_addr; inst_valid <= 0; counter <= 0; state <= REQ.
  - readM is high in the next cycle.
- REQ with inputReady=1 at an edge: inst_reg <= mem_data; inst_valid <= 1; state <= DONE.
- REQ with inputReady=0:
  - counter increments.
  - When counter == TIMEOUT_CYCLES-1 at the edge, state <= ERR and readM drops.
  - inputReady on that same edge wins and the fetch goes to DONE.
- DONE: unconditional return to IDLE after one cycle. fetch_start is ignored in DONE.
- ERR: held until fetch_start (retry at the new inst_addr) or flush (to IDLE). inst_valid stays 0.
- flush=1 at any edge:
  - state <= IDLE; inst_valid <= 0; inst_reg is held.
  - flush has priority over inputReady, fetch_start and timeout. Data arriving on that edge is discarded.
- fetch_start while in REQ or DONE: ignored, with no queuing.
- inputReady in IDLE, DONE or ERR: ignored; inst_reg is unchanged.
- inst_valid and inst_reg hold after DONE until the next accepted fetch_start or flush. The decode stage reads them across multiple cycles.
- Latency:
  - Accept at edge N; inputReady sampled at edge N+k (k>=1).
  - inst_reg is valid from edge N+k; fetch_done is high in cycle N+k..N+k+1; IDLE from edge N+k+1.
  - Minimum start-to-done is 1 cycle.
- fetch_addr does not change while readM is high, regardless of inst_addr (PC may update next-PC registers during the fetch).

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: num_inst increments by 1 on each REQ->DONE transition and wraps from 0xFFFF to 0x0000. Flushed and timed-out fetches are not counted. Reset clears it.
- Undefined: the port remains, num_inst is tied to 0, and no counter logic is present.

Test Plan:
- Basic fetch: reset, inst_addr=0x0000, fetch_start 1 cycle, inputReady with mem_data=0x6A01 two cycles later -> readM high 2 cycles, fetch_addr=0x0000, inst_reg=0x6A01, inst_valid=1, fetch_done single pulse, IDLE after.
- Address stability: fetch_start at inst_addr=0x0010, change inst_addr to 0x0011 during REQ -> fetch_addr stays 0x0010 until DONE.
- Timeout: TIMEOUT_CYCLES=4, no inputReady -> readM high exactly 4 cycles, then fetch_err=1, inst_valid=0. Then fetch_start at 0x0020 with inputReady -> fetch_err clears, inst_reg loaded.
- Flush race: flush and inputReady (mem_data=0xBEEF) on same edge -> IDLE, inst_valid=0, inst_reg keeps previous value, num_inst unchanged.
- Async reset mid-REQ: assert reset_n low between edges -> readM, fetch_busy, inst_valid drop immediately. Release -> IDLE, and inputReady afterward is ignored.
- FETCH_COUNT_EN: preload path via 0xFFFF successful fetches (or force) -> num_inst wraps to 0x0000. Without macro, num_inst==0 throughout.
